// File: rtl/mask_enc_pkg.sv
// ============================================================================
// Module   : mask_enc_pkg
// Brief    : Shared constants and state type for the 32-to-5 mask encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mask_enc_pkg;

   localparam int ENC_WIDTH = 32;
   localparam int ENC_IDX_W = 5;

   typedef enum logic [0:0] {
      ENC_IDLE = 1'b0,
      ENC_EMIT = 1'b1
   } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/prio_enc_32to5.sv
// ============================================================================
// Module   : prio_enc_32to5
// Brief    : Combinational lowest-set-bit encoder with any/one-hot flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prio_enc_32to5
   import mask_enc_pkg::*;
(
   input  logic [ENC_WIDTH-1:0] in,
   output logic [ENC_IDX_W-1:0] idx,
   output logic                 any,
   output logic                 one_hot
);

   always_comb begin
      idx = '0;
      // Descending scan so the lowest set bit is the last assignment to win.
      for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
         if (in[i]) begin
            idx = ENC_IDX_W'(i);
         end
      end
   end

   assign any     = |in;
   assign one_hot = any && ((in & (in - 1'b1)) == '0);

endmodule

`default_nettype wire

// File: rtl/mask_enc_32to5.sv
// ============================================================================
// Module   : mask_enc_32to5
// Brief    : Sequential mask encoder emitting each set-bit index, lowest first,
//            over a valid/ready handshake. Optional abort via MASK_ENC_ABORT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mask_enc_32to5
   import mask_enc_pkg::*;
#(
   parameter int WIDTH = ENC_WIDTH,
   parameter int IDX_W = ENC_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_mask,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [IDX_W-1:0] idx,
   output logic             idx_last,
   output logic             busy,
   output logic             done,
`ifdef MASK_ENC_ABORT_EN
   input  logic             abort,
`endif
   output logic [IDX_W:0]   count
);

   enc_state_t       state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             done_q, done_d;

   logic [IDX_W-1:0] w_enc_idx;
   logic             w_enc_any;
   logic             w_enc_one_hot;
   logic             w_xfer;
   logic             w_abort;

   prio_enc_32to5 u_prio_enc (
      .in      (remaining_q),
      .idx     (w_enc_idx),
      .any     (w_enc_any),
      .one_hot (w_enc_one_hot)
   );

`ifdef MASK_ENC_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_xfer = (state_q == ENC_EMIT) && idx_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      done_d      = 1'b0;
      case (state_q)
         ENC_IDLE: begin
            if (load_valid) begin
               remaining_d = load_mask;
               count_d     = '0;
               if (load_mask != '0) begin
                  state_d = ENC_EMIT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ENC_EMIT: begin
            if (w_xfer) begin
               // Clearing the lowest set bit is the same as clearing bit idx.
               remaining_d = remaining_q & (remaining_q - 1'b1);
               count_d     = count_q + 1'b1;
               if (w_enc_one_hot) begin
                  state_d = ENC_IDLE;
                  done_d  = 1'b1;
               end
            end
            if (w_abort) begin
               state_d     = ENC_IDLE;
               remaining_d = '0;
               done_d      = 1'b0;
            end
         end
         default: begin
            state_d = ENC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ENC_IDLE;
         remaining_q <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
   end

   assign busy       = (state_q == ENC_EMIT);
   assign load_ready = (state_q == ENC_IDLE);
   assign idx_valid  = busy && w_enc_any;
   assign idx        = busy ? w_enc_idx : '0;
   assign idx_last   = busy && w_enc_one_hot;
   assign done       = done_q;
   assign count      = count_q;

endmodule

`default_nettype wire
